// File: rtl/dram_req_arb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_req_arb_queue_if
// Description : Bundle of the per-channel enqueue ports, transaction-counter
//               controls and the arbitrated DRAM request port of
//               dram_req_arb_queue. The slave side is the queue, the master
//               side is the backend/DRAM environment driving it.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_req_arb_queue_if #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int NB_W   = 6,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // Per-channel enqueue ports
   logic [NUM_CH-1:0]        enq_valid;
   logic [NUM_CH-1:0]        enq_ready;
   logic [NUM_CH-1:0]        enq_write;
   logic [NUM_CH*ID_W-1:0]   enq_id;
   logic [NUM_CH*ADDR_W-1:0] enq_addr;
   logic [NUM_CH*NB_W-1:0]   enq_num_bytes;
   logic [NUM_CH*DATA_W-1:0] enq_wdata;

   // Per-channel transaction counters and status
   logic [NUM_CH-1:0]        txn_start;
   logic [NUM_CH*LEN_W-1:0]  txn_len;
   logic [NUM_CH-1:0]        txn_busy;
   logic [NUM_CH-1:0]        txn_done;
   logic [NUM_CH*CNT_W-1:0]  occupancy;

   // Arbitrated DRAM request port
   logic                     dram_req_valid;
   logic                     dram_req_ready;
   logic [CH_W-1:0]          dram_req_ch;
   logic                     dram_req_write;
   logic [ID_W-1:0]          dram_req_id;
   logic [ADDR_W-1:0]        dram_req_addr;
   logic [NB_W-1:0]          dram_req_num_bytes;
   logic [DATA_W-1:0]        dram_req_wdata;
   logic [31:0]              perf_stall_cycles;

   modport slave (
      input  enq_valid, enq_write, enq_id, enq_addr, enq_num_bytes, enq_wdata,
      input  txn_start, txn_len, dram_req_ready,
      output enq_ready, txn_busy, txn_done, occupancy,
      output dram_req_valid, dram_req_ch, dram_req_write, dram_req_id,
      output dram_req_addr, dram_req_num_bytes, dram_req_wdata, perf_stall_cycles
   );

   modport master (
      output enq_valid, enq_write, enq_id, enq_addr, enq_num_bytes, enq_wdata,
      output txn_start, txn_len, dram_req_ready,
      input  enq_ready, txn_busy, txn_done, occupancy,
      input  dram_req_valid, dram_req_ch, dram_req_write, dram_req_id,
      input  dram_req_addr, dram_req_num_bytes, dram_req_wdata, perf_stall_cycles
   );
endinterface
`default_nettype wire

// File: rtl/dram_req_arb_queue.sv
`default_nettype none
// ============================================================================
// Module      : dram_req_arb_queue
// Description : NUM_CH per-channel request FIFOs drained by a stall-safe
//               round-robin arbiter onto one valid/ready DRAM request port,
//               with a per-channel accepted-request transaction counter.
//               Optional macro DRAM_REQ_ARB_QUEUE_PERF_EN enables the
//               saturating perf_stall_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_req_arb_queue #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32,
   parameter int ID_W   = 8,
   parameter int NB_W   = 6,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   dram_req_arb_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ENT_W = 1 + ID_W + ADDR_W + NB_W + DATA_W;

   // Entry layout: {write, id, addr, num_bytes, wdata}
   logic [ENT_W-1:0] mem_q [NUM_CH][DEPTH];
   logic [ENT_W-1:0] mem_d [NUM_CH][DEPTH];
   logic [PTR_W-1:0] head_q [NUM_CH], head_d [NUM_CH];
   logic [PTR_W-1:0] tail_q [NUM_CH], tail_d [NUM_CH];
   logic [CNT_W-1:0] count_q [NUM_CH], count_d [NUM_CH];
   logic [LEN_W-1:0] len_q [NUM_CH], len_d [NUM_CH];
   logic [LEN_W-1:0] acc_q [NUM_CH], acc_d [NUM_CH];
   logic [NUM_CH-1:0] busy_q, busy_d, done_q, done_d;
   logic             lock_q, lock_d;
   logic [CH_W-1:0]  grant_q, grant_d, rr_q, rr_d;

   logic [ENT_W-1:0]  enq_ent [NUM_CH];
   logic [NUM_CH-1:0] nonempty, push, pop;
   logic [CH_W-1:0]   grant;
   logic              req_valid, accept;
   logic [ENT_W-1:0]  head_ent;

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         assign enq_ent[c] = {bus.enq_write[c], bus.enq_id[c*ID_W +: ID_W],
                              bus.enq_addr[c*ADDR_W +: ADDR_W],
                              bus.enq_num_bytes[c*NB_W +: NB_W],
                              bus.enq_wdata[c*DATA_W +: DATA_W]};
         // Ready comes from the registered count only: no pop-to-push bypass
         assign bus.enq_ready[c]                = (count_q[c] != CNT_W'(DEPTH));
         assign bus.occupancy[c*CNT_W +: CNT_W] = count_q[c];
         assign nonempty[c]                     = (count_q[c] != '0);
         assign push[c]                         = bus.enq_valid[c] && bus.enq_ready[c];
         assign pop[c]                          = accept && (grant == CH_W'(c));
      end
   endgenerate

   // Round-robin search from rr_ptr; a locked grant is held until accepted
   always_comb begin
      logic [CH_W:0] idx;
      logic          found;
      grant = grant_q;
      found = 1'b0;
      idx   = '0;
      if (!lock_q) begin
         grant = rr_q;
         for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_q} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (!found && nonempty[idx[CH_W-1:0]]) begin
               grant = idx[CH_W-1:0];
               found = 1'b1;
            end
         end
      end
      req_valid = lock_q || (|nonempty);
      accept    = req_valid && bus.dram_req_ready;
      head_ent  = mem_q[grant][head_q[grant]];
      lock_d    = req_valid && !bus.dram_req_ready;
      grant_d   = grant;
      rr_d      = rr_q;
      if (accept) begin
         if (grant == CH_W'(NUM_CH - 1)) rr_d = '0;
         else                            rr_d = grant + CH_W'(1);
      end
   end

   // FIFO pointer/storage update and per-channel transaction counting
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      len_d   = len_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      done_d  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) begin
            mem_d[c][tail_q[c]] = enq_ent[c];
            tail_d[c]           = tail_q[c] + PTR_W'(1);
         end
         if (pop[c]) head_d[c] = head_q[c] + PTR_W'(1);
         count_d[c] = count_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
         if (busy_q[c]) begin
            if (pop[c]) begin
               if (acc_q[c] + LEN_W'(1) == len_q[c]) begin
                  done_d[c] = 1'b1;
                  busy_d[c] = 1'b0;
                  acc_d[c]  = '0;
               end else begin
                  acc_d[c] = acc_q[c] + LEN_W'(1);
               end
            end
         end else if (bus.txn_start[c]) begin
            // A zero-length transaction completes without ever going busy
            if (bus.txn_len[c*LEN_W +: LEN_W] == '0) begin
               done_d[c] = 1'b1;
            end else begin
               busy_d[c] = 1'b1;
               len_d[c]  = bus.txn_len[c*LEN_W +: LEN_W];
               acc_d[c]  = '0;
            end
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            for (int e = 0; e < DEPTH; e++) mem_q[c][e] <= '0;
            head_q[c]  <= '0;
            tail_q[c]  <= '0;
            count_q[c] <= '0;
            len_q[c]   <= '0;
            acc_q[c]   <= '0;
         end
         busy_q  <= '0;
         done_q  <= '0;
         lock_q  <= 1'b0;
         grant_q <= '0;
         rr_q    <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lock_q  <= lock_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   assign bus.txn_busy           = busy_q;
   assign bus.txn_done           = done_q;
   assign bus.dram_req_valid     = req_valid;
   // Fields read as zero whenever nothing is presented
   assign bus.dram_req_ch        = req_valid ? grant : '0;
   assign bus.dram_req_write     = req_valid & head_ent[ENT_W-1];
   assign bus.dram_req_id        = req_valid ? head_ent[DATA_W+NB_W+ADDR_W +: ID_W] : '0;
   assign bus.dram_req_addr      = req_valid ? head_ent[DATA_W+NB_W +: ADDR_W] : '0;
   assign bus.dram_req_num_bytes = req_valid ? head_ent[DATA_W +: NB_W] : '0;
   assign bus.dram_req_wdata     = req_valid ? head_ent[DATA_W-1:0] : '0;

`ifdef DRAM_REQ_ARB_QUEUE_PERF_EN
   logic [31:0] stall_q, stall_d;

   // Saturating count of cycles a presented request is held off by DRAM
   always_comb begin
      stall_d = stall_q;
      if (req_valid && !bus.dram_req_ready && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   // Stall counter register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign bus.perf_stall_cycles = stall_q;
`else
   assign bus.perf_stall_cycles = 32'd0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_dram_req_arb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_req_arb_queue
// Description : Directed self-checking bench for dram_req_arb_queue
//               (defaults: NUM_CH=2, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_req_arb_queue;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   vectors = 0;
   int   fails   = 0;

   always #5 clk = ~clk;

   dram_req_arb_queue_if #(.NUM_CH(2), .DEPTH(8)) bus ();

   dram_req_arb_queue #(.NUM_CH(2), .DEPTH(8)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.enq_valid      = '0;
      bus.enq_write      = '0;
      bus.enq_id         = '0;
      bus.enq_addr       = '0;
      bus.enq_num_bytes  = '0;
      bus.enq_wdata      = '0;
      bus.txn_start      = '0;
      bus.txn_len        = '0;
      bus.dram_req_ready = 1'b0;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
      tick();
   endtask

   // Present one push on channel ch (value only; caller ticks)
   task automatic drive_push(input int ch, input logic [7:0] id, input logic wr,
                             input logic [63:0] data);
      bus.enq_valid              = '0;
      bus.enq_valid[ch]          = 1'b1;
      bus.enq_write[ch]          = wr;
      bus.enq_id[ch*8 +: 8]      = id;
      bus.enq_addr[ch*32 +: 32]  = 32'h1000 + 32'(id) * 32'd8;
      bus.enq_num_bytes[ch*6 +: 6] = 6'd8;
      bus.enq_wdata[ch*64 +: 64] = data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      tick();
      tick();
      // Reset values
      check("rst_enq_ready", 64'(bus.enq_ready), 64'h3);
      check("rst_valid", 64'(bus.dram_req_valid), 64'h0);
      check("rst_busy", 64'(bus.txn_busy), 64'h0);
      check("rst_done", 64'(bus.txn_done), 64'h0);
      check("rst_occ", 64'(bus.occupancy), 64'h0);
      check("rst_id", 64'(bus.dram_req_id), 64'h0);
      check("rst_addr", 64'(bus.dram_req_addr), 64'h0);
      n_rst = 1'b1;
      tick();

      // Fill ch0 with 8 reads while DRAM stalls
      for (int i = 0; i < 8; i++) begin
         drive_push(0, 8'(i), 1'b0, 64'h0);
         tick();
      end
      check("fill_enq_ready0", 64'(bus.enq_ready[0]), 64'h0);
      check("fill_occ0", 64'(bus.occupancy[3:0]), 64'h8);
      drive_push(0, 8'h08, 1'b0, 64'h0);
      tick();
      check("drop_occ0", 64'(bus.occupancy[3:0]), 64'h8);
      bus.enq_valid = '0;
      bus.dram_req_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 64'(bus.dram_req_valid), 64'h1);
         check("drain_ch", 64'(bus.dram_req_ch), 64'h0);
         check("drain_id", 64'(bus.dram_req_id), 64'(i));
         check("drain_addr", 64'(bus.dram_req_addr), 64'h1000 + 64'(i) * 64'd8);
         tick();
      end
      check("drain_empty_valid", 64'(bus.dram_req_valid), 64'h0);
      check("drain_empty_occ", 64'(bus.occupancy), 64'h0);

      // Round robin: 3 entries on each channel
      idle_inputs();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_push(0, 8'h20 + 8'(i), 1'b0, 64'h0);
         bus.enq_valid[1]    = 1'b1;
         bus.enq_id[15:8]    = 8'h30 + 8'(i);
         bus.enq_addr[63:32] = 32'h2000;
         tick();
      end
      check("rr_occ", 64'(bus.occupancy), 64'h33);
      bus.enq_valid = '0;
      bus.dram_req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("rr_ch", 64'(bus.dram_req_ch), 64'(i % 2));
         check("rr_id", 64'(bus.dram_req_id), (i % 2 == 0) ? 64'h20 + 64'(i/2) : 64'h30 + 64'(i/2));
         tick();
      end
      check("rr_done_valid", 64'(bus.dram_req_valid), 64'h0);

      // Stall lock: ch1 held for 5 cycles, ch0 arrives meanwhile
      idle_inputs();
      do_reset();
      drive_push(1, 8'h11, 1'b1, 64'hDEAD_BEEF);
      tick();
      bus.enq_valid = '0;
      for (int i = 0; i < 5; i++) begin
         check("lock_ch", 64'(bus.dram_req_ch), 64'h1);
         check("lock_id", 64'(bus.dram_req_id), 64'h11);
         if (i == 1) drive_push(0, 8'h22, 1'b0, 64'h0);
         else        bus.enq_valid = '0;
         tick();
      end
      bus.enq_valid = '0;
`ifdef DRAM_REQ_ARB_QUEUE_PERF_EN
      check("perf_stall", 64'(bus.perf_stall_cycles), 64'd5);
`else
      check("perf_tied", 64'(bus.perf_stall_cycles), 64'd0);
`endif
      bus.dram_req_ready = 1'b1;
      check("unlock_ch1", 64'(bus.dram_req_ch), 64'h1);
      check("unlock_wdata", bus.dram_req_wdata, 64'hDEAD_BEEF);
      tick();
      check("after_ch0", 64'(bus.dram_req_ch), 64'h0);
      check("after_id", 64'(bus.dram_req_id), 64'h22);
      tick();

      // Transaction of 4 on ch0
      bus.dram_req_ready = 1'b0;
      bus.txn_start = 2'b01;
      bus.txn_len   = 16'h0004;
      tick();
      bus.txn_start = '0;
      check("txn_busy_set", 64'(bus.txn_busy), 64'h1);
      for (int i = 0; i < 4; i++) begin
         drive_push(0, 8'h40 + 8'(i), 1'b0, 64'h0);
         tick();
      end
      bus.enq_valid = '0;
      bus.dram_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("txn_id", 64'(bus.dram_req_id), 64'h40 + 64'(i));
         check("txn_no_done", 64'(bus.txn_done), 64'h0);
         tick();
      end
      check("txn_done", 64'(bus.txn_done), 64'h1);
      check("txn_busy_clr", 64'(bus.txn_busy), 64'h0);
      tick();
      check("txn_done_pulse", 64'(bus.txn_done), 64'h0);

      // Zero-length transaction
      bus.txn_start = 2'b01;
      bus.txn_len   = 16'h0000;
      tick();
      bus.txn_start = '0;
      check("zero_done", 64'(bus.txn_done), 64'h1);
      check("zero_busy", 64'(bus.txn_busy), 64'h0);
      tick();
      check("zero_done_pulse", 64'(bus.txn_done), 64'h0);

      // Re-arm while busy is ignored
      bus.dram_req_ready = 1'b0;
      bus.txn_start = 2'b01;
      bus.txn_len   = 16'h0002;
      tick();
      check("rearm_busy", 64'(bus.txn_busy), 64'h1);
      bus.txn_len   = 16'h0009;
      drive_push(0, 8'h50, 1'b0, 64'h0);
      tick();
      bus.txn_start = '0;
      drive_push(0, 8'h51, 1'b0, 64'h0);
      tick();
      bus.enq_valid = '0;
      bus.dram_req_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("rearm_no_done", 64'(bus.txn_done), 64'h0);
         tick();
      end
      check("rearm_done", 64'(bus.txn_done), 64'h1);
      check("rearm_busy_clr", 64'(bus.txn_busy), 64'h0);

      // Streaming 20 writes through ch1 across pointer wrap
      for (int k = 0; k <= 20; k++) begin
         if (k < 20) drive_push(1, 8'h60 + 8'(k), 1'b1, 64'hA5A5_0000_0000_0000 + 64'(k));
         else        bus.enq_valid = '0;
         if (k >= 1) begin
            check("wrap_ch", 64'(bus.dram_req_ch), 64'h1);
            check("wrap_id", 64'(bus.dram_req_id), 64'h60 + 64'(k - 1));
            check("wrap_wdata", bus.dram_req_wdata, 64'hA5A5_0000_0000_0000 + 64'(k - 1));
            check("wrap_write", 64'(bus.dram_req_write), 64'h1);
         end
         tick();
      end
      check("wrap_empty", 64'(bus.dram_req_valid), 64'h0);

      // Reset with 3 entries queued and a transaction armed
      bus.dram_req_ready = 1'b0;
      bus.txn_start = 2'b01;
      bus.txn_len   = 16'h0003;
      tick();
      bus.txn_start = '0;
      for (int i = 0; i < 3; i++) begin
         drive_push(0, 8'h70 + 8'(i), 1'b0, 64'h0);
         tick();
      end
      bus.enq_valid = '0;
      check("pre_rst_occ", 64'(bus.occupancy[3:0]), 64'h3);
      bus.dram_req_ready = 1'b1;
      n_rst = 1'b0;
      #1;
      check("async_rst_occ", 64'(bus.occupancy), 64'h0);
      check("async_rst_valid", 64'(bus.dram_req_valid), 64'h0);
      check("async_rst_busy", 64'(bus.txn_busy), 64'h0);
      tick();
      check("rst_no_done", 64'(bus.txn_done), 64'h0);
      n_rst = 1'b1;
      tick();
      check("post_rst_done", 64'(bus.txn_done), 64'h0);
      check("post_rst_valid", 64'(bus.dram_req_valid), 64'h0);
      check("post_rst_ready", 64'(bus.enq_ready), 64'h3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
`default_nettype wire
